// File: rtl/ddr_cmd_sequencer.sv
// DDR SDRAM command sequencer: power-up init, closed-page ACT -> RD/WR -> PRE trains
// and periodic auto-refresh, with every command gap timed by one shared wait counter.
module ddr_cmd_sequencer #(
    parameter int unsigned      ROW_W       = 13,
    parameter int unsigned      COL_W       = 10,
    parameter int unsigned      BANK_W      = 2,
    parameter int unsigned      T_RCD       = 3,
    parameter int unsigned      T_RP        = 3,
    parameter int unsigned      T_RW2PRE    = 4,
    parameter int unsigned      T_RFC       = 10,
    parameter int unsigned      T_MRD       = 2,
    parameter int unsigned      T_REFI      = 200,
    parameter int unsigned      INIT_CYCLES = 20,
    parameter logic [ROW_W-1:0] MODE_REG    = 13'h0031
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Write,
    input  logic [BANK_W-1:0] Req_Bank,
    input  logic [ROW_W-1:0]  Req_Row,
    input  logic [COL_W-1:0]  Req_Col,
    output logic [3:0]        Cmd,
    output logic [BANK_W-1:0] Ba,
    output logic [ROW_W-1:0]  Addr,
    output logic              Init_Done,
    output logic              Ref_Overrun
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned WAIT_MAX = max2(INIT_CYCLES, max2(max2(T_RCD, T_RP),
                                       max2(max2(T_RW2PRE, T_RFC), T_MRD)));
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int unsigned REF_W    = (T_REFI > 1) ? $clog2(T_REFI) : 1;
    localparam int unsigned AP_BIT   = 10;

    typedef enum logic [3:0] {
        CMD_MRS = 4'b0000,
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_NOP = 4'b0111
    } cmd_e;

    // Each state names the last command issued; the wait counter holds off the next one.
    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_PRE,
        S_INIT_MRS,
        S_INIT_REF1,
        S_INIT_REF2,
        S_IDLE,
        S_ACT,
        S_RW,
        S_PRE,
        S_REF
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    cmd_e                cmd_q, cmd_d;
    logic [BANK_W-1:0]   ba_q, ba_d;
    logic [ROW_W-1:0]    addr_q, addr_d;
    logic                init_done_q, init_done_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic                write_q, write_d;
    logic [REF_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic                ref_pending_q, ref_pending_d;
    logic                ref_overrun_q, ref_overrun_d;
    logic                timer_done;
    logic                ref_issue;
    logic                ref_wrap;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        cmd_d       = CMD_NOP;
        ba_d        = '0;
        addr_d      = '0;
        init_done_d = init_done_q;
        bank_d      = bank_q;
        col_d       = col_q;
        write_d     = write_q;
        ref_issue   = 1'b0;
        timer_done  = (wait_q == '0);

        if (!timer_done) begin
            wait_d = wait_q - WAIT_W'(1);
        end

        unique case (state_q)
            S_INIT_WAIT: if (timer_done) begin
                cmd_d          = CMD_PRE;
                addr_d[AP_BIT] = 1'b1;
                wait_d         = WAIT_W'(T_RP - 1);
                state_d        = S_INIT_PRE;
            end
            S_INIT_PRE: if (timer_done) begin
                cmd_d   = CMD_MRS;
                addr_d  = MODE_REG;
                wait_d  = WAIT_W'(T_MRD - 1);
                state_d = S_INIT_MRS;
            end
            S_INIT_MRS: if (timer_done) begin
                cmd_d   = CMD_REF;
                wait_d  = WAIT_W'(T_RFC - 1);
                state_d = S_INIT_REF1;
            end
            S_INIT_REF1: if (timer_done) begin
                cmd_d   = CMD_REF;
                wait_d  = WAIT_W'(T_RFC - 1);
                state_d = S_INIT_REF2;
            end
            S_INIT_REF2: if (timer_done) begin
                init_done_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_IDLE: begin
                // A pending refresh wins; Req_Ready is low whenever one is pending.
                if (ref_pending_q) begin
                    cmd_d     = CMD_REF;
                    ref_issue = 1'b1;
                    wait_d    = WAIT_W'(T_RFC - 1);
                    state_d   = S_REF;
                end else if (Req_Valid) begin
                    cmd_d   = CMD_ACT;
                    ba_d    = Req_Bank;
                    addr_d  = Req_Row;
                    bank_d  = Req_Bank;
                    col_d   = Req_Col;
                    write_d = Req_Write;
                    wait_d  = WAIT_W'(T_RCD - 1);
                    state_d = S_ACT;
                end
            end
            S_ACT: if (timer_done) begin
                cmd_d               = write_q ? CMD_WR : CMD_RD;
                ba_d                = bank_q;
                addr_d[COL_W-1:0]   = col_q;
                wait_d              = WAIT_W'(T_RW2PRE - 1);
                state_d             = S_RW;
            end
            S_RW: if (timer_done) begin
                cmd_d   = CMD_PRE;
                ba_d    = bank_q;
                wait_d  = WAIT_W'(T_RP - 1);
                state_d = S_PRE;
            end
            S_PRE: if (timer_done) begin
                state_d = S_IDLE;
            end
            S_REF: if (timer_done) begin
                state_d = S_IDLE;
            end
            default: state_d = S_INIT_WAIT;
        endcase
    end

    // Refresh interval timer runs only once init has finished.
    always_comb begin
        ref_wrap      = init_done_q && (ref_cnt_q == REF_W'(T_REFI - 1));
        ref_cnt_d     = ref_cnt_q;
        ref_pending_d = ref_pending_q;
        ref_overrun_d = ref_overrun_q | (ref_wrap & ref_pending_q);
        if (init_done_q) begin
            ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
        end
        if (ref_wrap) begin
            ref_pending_d = 1'b1;
        end else if (ref_issue) begin
            ref_pending_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= S_INIT_WAIT;
            wait_q        <= WAIT_W'(INIT_CYCLES);
            cmd_q         <= CMD_NOP;
            ba_q          <= '0;
            addr_q        <= '0;
            init_done_q   <= 1'b0;
            bank_q        <= '0;
            col_q         <= '0;
            write_q       <= 1'b0;
            ref_cnt_q     <= '0;
            ref_pending_q <= 1'b0;
            ref_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            cmd_q         <= cmd_d;
            ba_q          <= ba_d;
            addr_q        <= addr_d;
            init_done_q   <= init_done_d;
            bank_q        <= bank_d;
            col_q         <= col_d;
            write_q       <= write_d;
            ref_cnt_q     <= ref_cnt_d;
            ref_pending_q <= ref_pending_d;
            ref_overrun_q <= ref_overrun_d;
        end
    end

    assign Req_Ready   = (state_q == S_IDLE) && !ref_pending_q;
    assign Cmd         = cmd_q;
    assign Ba          = ba_q;
    assign Addr        = addr_q;
    assign Init_Done   = init_done_q;
    assign Ref_Overrun = ref_overrun_q;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Bench for ddr_cmd_sequencer: a cycle-indexed expected-command schedule built from the
// timing rules, driven by directed and random requests, plus a short-T_REFI overrun instance.
module tb_ddr_cmd_sequencer;

    localparam int ROW_W       = 13;
    localparam int COL_W       = 10;
    localparam int BANK_W      = 2;
    localparam int T_RCD       = 3;
    localparam int T_RP        = 3;
    localparam int T_RW2PRE    = 4;
    localparam int T_RFC       = 10;
    localparam int T_MRD       = 2;
    localparam int T_REFI      = 200;
    localparam int INIT_CYCLES = 20;
    localparam int INIT_DONE   = INIT_CYCLES + T_RP + T_MRD + 2 * T_RFC;
    localparam int TRAIN_GAP   = 1 + T_RCD + T_RW2PRE + T_RP;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              req_valid;
    logic              req_write;
    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;
    logic [COL_W-1:0]  req_col;
    logic              req_ready;
    logic [3:0]        cmd;
    logic [BANK_W-1:0] ba;
    logic [ROW_W-1:0]  addr;
    logic              init_done;
    logic              ref_overrun;

    logic              ov_ready;
    logic [3:0]        ov_cmd;
    logic [BANK_W-1:0] ov_ba;
    logic [ROW_W-1:0]  ov_addr;
    logic              ov_init_done;
    logic              ov_overrun;

    ddr_cmd_sequencer dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .Req_Valid  (req_valid),
        .Req_Ready  (req_ready),
        .Req_Write  (req_write),
        .Req_Bank   (req_bank),
        .Req_Row    (req_row),
        .Req_Col    (req_col),
        .Cmd        (cmd),
        .Ba         (ba),
        .Addr       (addr),
        .Init_Done  (init_done),
        .Ref_Overrun(ref_overrun)
    );

    // Continuous request stream against a refresh interval shorter than one train.
    ddr_cmd_sequencer #(.T_REFI(8)) dut_ov (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .Req_Valid  (1'b1),
        .Req_Ready  (ov_ready),
        .Req_Write  (1'b0),
        .Req_Bank   (2'd1),
        .Req_Row    (13'h0005),
        .Req_Col    (10'h007),
        .Cmd        (ov_cmd),
        .Ba         (ov_ba),
        .Addr       (ov_addr),
        .Init_Done  (ov_init_done),
        .Ref_Overrun(ov_overrun)
    );

    int total;
    int bad;
    int cyc;
    int idle_from;
    bit pend;
    bit ovr;
    logic [3:0]        exp_cmd  [int];
    logic [BANK_W-1:0] exp_ba   [int];
    logic [ROW_W-1:0]  exp_addr [int];
    int                hs_q     [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic sched(input int c, input logic [3:0] k, input logic [BANK_W-1:0] b,
                         input logic [ROW_W-1:0] a);
        exp_cmd[c]  = k;
        exp_ba[c]   = b;
        exp_addr[c] = a;
    endtask

    task automatic model_reset();
        exp_cmd.delete();
        exp_ba.delete();
        exp_addr.delete();
        hs_q.delete();
        pend      = 1'b0;
        ovr       = 1'b0;
        cyc       = 0;
        sched(INIT_CYCLES, C_PRE, '0, 13'h0400);
        sched(INIT_CYCLES + T_RP, C_MRS, '0, 13'h0031);
        sched(INIT_CYCLES + T_RP + T_MRD, C_REF, '0, '0);
        sched(INIT_CYCLES + T_RP + T_MRD + T_RFC, C_REF, '0, '0);
        idle_from = INIT_DONE;
    endtask

    // Check the current cycle against the schedule, extend the schedule, then advance one cycle.
    task automatic run_cycle(input bit v, input bit w, input logic [BANK_W-1:0] b,
                             input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        logic [3:0] ec;
        bit         wrap;
        bit         ready_m;
        int         a;
        wrap = (cyc > INIT_DONE) && (((cyc - INIT_DONE) % T_REFI) == 0);
        ec   = exp_cmd.exists(cyc) ? exp_cmd[cyc] : C_NOP;
        if (wrap && pend) ovr = 1'b1;
        if (wrap) pend = 1'b1;
        else if (ec == C_REF && cyc > INIT_DONE) pend = 1'b0;

        check("cmd", 32'(cmd), 32'(ec));
        if (ec != C_NOP) begin
            check("ba", 32'(ba), 32'(exp_ba[cyc]));
            check("addr", 32'(addr), 32'(exp_addr[cyc]));
        end
        ready_m = (cyc >= idle_from) && !pend;
        check("ready", 32'(req_ready), 32'(ready_m));
        check("init_done", 32'(init_done), 32'(cyc >= INIT_DONE));
        check("ref_overrun", 32'(ref_overrun), 32'(ovr));
        if (cyc == 50) check("ov_overrun_early", 32'(ov_overrun), 32'd0);
        if (cyc >= 100) check("ov_overrun_sticky", 32'(ov_overrun), 32'd1);

        if (req_ready && v) hs_q.push_back(cyc);
        if (cyc >= idle_from && pend) begin
            sched(cyc + 1, C_REF, '0, '0);
            idle_from = cyc + 1 + T_RFC;
        end else if (ready_m && v) begin
            a = cyc + 1;
            sched(a, C_ACT, b, r);
            sched(a + T_RCD, w ? C_WR : C_RD, b, ROW_W'(c));
            sched(a + T_RCD + T_RW2PRE, C_PRE, b, '0);
            idle_from = a + T_RCD + T_RW2PRE + T_RP;
        end

        req_valid = v;
        req_write = w;
        req_bank  = b;
        req_row   = r;
        req_col   = c;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_random(input bit force_valid, input bit force_write);
        bit v;
        bit w;
        v = force_valid ? 1'b1 : 1'($urandom_range(0, 1));
        w = force_write ? 1'b1 : 1'($urandom_range(0, 1));
        run_cycle(v, w, BANK_W'($urandom), ROW_W'($urandom), COL_W'($urandom));
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_bank  = '0;
        req_row   = '0;
        req_col   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", 32'(cmd), 32'(C_NOP));
        check("rst_ba", 32'(ba), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_overrun", 32'(ref_overrun), 32'd0);
        check("rst_ov_overrun", 32'(ov_overrun), 32'd0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bound;
        int n;
        total = 0;
        bad   = 0;
        cyc   = 0;
        apply_reset();

        // Init sequence with no requests.
        while (cyc < INIT_DONE) run_cycle(1'b0, 1'b0, '0, '0, '0);

        // Directed read at the first Ready cycle.
        run_cycle(1'b1, 1'b0, 2'd2, 13'h1ABC, 10'h155);
        repeat (TRAIN_GAP - 1) run_cycle(1'b0, 1'b0, '0, '0, '0);

        // Back-to-back writes held valid, straddling the first refresh wrap.
        while (cyc < 275) run_random(1'b1, 1'b1);

        check("hs_read_cycle", 32'(hs_q[0]), 32'(INIT_DONE));
        check("hs_count", 32'(hs_q.size() >= 6), 32'd1);
        n = (hs_q.size() < 6) ? hs_q.size() : 6;
        for (int i = 1; i < n; i++) begin
            check("hs_gap", 32'(hs_q[i] - hs_q[i-1]), 32'(TRAIN_GAP));
        end

        // Random traffic across further refresh intervals.
        while (cyc < 660) run_random(1'b0, 1'b0);

        // Reset one cycle after an ACT.
        bound = 0;
        while (cmd !== C_ACT && bound < 50) begin
            run_random(1'b1, 1'b0);
            bound++;
        end
        check("act_before_reset", 32'(cmd), 32'(C_ACT));
        run_cycle(1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        check("abort_cmd", 32'(cmd), 32'(C_NOP));
        check("abort_ba", 32'(ba), 32'd0);
        check("abort_addr", 32'(addr), 32'd0);
        check("abort_ready", 32'(req_ready), 32'd0);
        check("abort_init_done", 32'(init_done), 32'd0);
        check("abort_ov_overrun", 32'(ov_overrun), 32'd0);

        // Init repeats with identical timing, then a little more traffic.
        apply_reset();
        while (cyc < INIT_DONE) run_cycle(1'b0, 1'b0, '0, '0, '0);
        while (cyc < 120) run_random(1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_sequencer.md
# ddr_cmd_sequencer

Parametrised DDR SDRAM command sequencer for the DDR verification environment. It runs the power-up init sequence itself: wait, PRECHARGE-ALL, LOAD MODE, two AUTO REFRESH. It then turns single read/write requests into closed-page ACT → RD/WR → PRE command trains, enforces tRCD/tRP/tRFC/tMRD spacing and schedules periodic auto-refresh. It sits between the environment's stimulus side and the DDR_Interface command pins, and replaces hand-timed command sequences in tests.

## Interface
- ROW_W, 13, row address width; also the width of Addr
- COL_W, 10, column width; must be ≤10 and ≤ROW_W
- BANK_W, 2, bank address width
- T_RCD, 3, cycles from ACT to RD/WR (≥1)
- T_RP, 3, cycles from PRE to the next command (≥1)
- T_RW2PRE, 4, cycles from RD/WR to PRE (≥1)
- T_RFC, 10, cycles from REF to the next command (≥1)
- T_MRD, 2, cycles from MRS to the next command (≥1)
- T_REFI, 200, refresh interval in cycles (> one full request train)
- INIT_CYCLES, 20, NOP cycles after reset before PRECHARGE-ALL
- MODE_REG, 13'h0031, value driven on Addr during MRS
- Clk  in  1  clock, rising-edge
- Rst_n  in  1  asynchronous, active-low reset
- Req_Valid  in  1  request present
- Req_Ready  out  1  sequencer accepts a request this cycle
- Req_Write  in  1  1 = write, 0 = read
- Req_Bank  in  BANK_W  target bank
- Req_Row  in  ROW_W  target row
- Req_Col  in  COL_W  target column
- Cmd  out  4  {CS_n,RAS_n,CAS_n,WE_n}
- Ba  out  BANK_W  bank address
- Addr  out  ROW_W  address bus
- Init_Done  out  1  init complete; stays high until reset
- Ref_Overrun  out  1  sticky: a refresh interval expired while a refresh was already pending

## Operation
- Cmd encodings: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001, MRS 0000. Each non-NOP command lasts exactly one cycle. All other cycles drive NOP.
- Reset (asynchronous): Cmd=0111, Ba=0, Addr=0, Req_Ready=0, Init_Done=0, Ref_Overrun=0, refresh counter=0, Ref_Pending=0, state=INIT_WAIT.
- States: INIT_WAIT → INIT_PRE → INIT_MRS → INIT_REF1 → INIT_REF2 → IDLE; IDLE → ACT → RW → PRE → IDLE; IDLE → REF → IDLE. A single shared wait counter enforces each timing gap.
- PRECHARGE-ALL: Addr[10]=1, Ba=0, other Addr bits 0.
- MRS: Addr=MODE_REG, Ba=0.
- ACT: Ba=bank, Addr=row.
- RD/WR: Ba=bank, Addr={zeros, col} with Addr[10]=0 (no auto-precharge).
- PRE: Ba=bank, Addr=0.
- Req_Ready=1 iff state is IDLE and Ref_Pending=0. Bank, row, col and write are registered on Req_Valid&Req_Ready. Inputs are ignored at all other times.
- Refresh counter starts when Init_Done rises and counts 0..T_REFI-1, then wraps. On wrap it sets Ref_Pending. If Ref_Pending is already set at wrap, Ref_Overrun is set (only one refresh stays pending).
- IDLE priority: a pending refresh beats a request. A refresh that becomes pending mid-train waits until the train returns to IDLE. REF clears Ref_Pending.
- If a wrap coincides with a handshake, the request is accepted and REF follows that train.
- Reset mid-operation aborts any train immediately. Init restarts from INIT_WAIT.

## Timing
- Cycle 0 is the first rising edge after Rst_n deasserts.
- Init schedule: PRE-all at INIT_CYCLES; MRS at +T_RP; REF at +T_MRD; second REF at +T_RFC. Init_Done and IDLE follow T_RFC later. With defaults: 20, 23, 25, 35; Init_Done=1 at 45.
- Request train, handshake at cycle h: ACT at h+1; RD/WR at h+1+T_RCD; PRE at h+1+T_RCD+T_RW2PRE; Req_Ready high again at h+1+T_RCD+T_RW2PRE+T_RP. With defaults the gap from handshake to next Ready is 11 cycles.
- REF issued at cycle r: Req_Ready stays low until r+T_RFC.
- Outputs are registered, with no combinational path from inputs to Cmd/Ba/Addr. Req_Ready is decoded from registers only.

## Test plan
- Reset release, no requests → PRE-all (Addr=0x400) at 20, MRS Addr=0x0031 at 23, REF at 25 and 35, Init_Done=1 at 45; NOP on every other cycle.
- Read at h: bank 2, row 0x1ABC, col 0x155 → ACT Ba=2 Addr=0x1ABC at h+1; RD Addr=0x155 at h+4; PRE Ba=2 at h+8; Ready at h+11.
- Back-to-back write requests held valid → next handshake exactly 11 cycles after the previous one; no command spacing violated.
- Refresh wrap during a train → train completes, REF issued in the first IDLE cycle, Ready low for 10 cycles after it, Ref_Overrun stays 0.
- T_REFI=8 override with a continuous request stream → Ref_Overrun goes 1 and stays 1 until reset.
- Rst_n asserted one cycle after ACT → Cmd=0111 immediately; after release the full init sequence repeats with the same timing.
